// File: rtl/rca_job_arbiter.sv
// Two-requester round-robin front end for a shared ap_ctrl_hs ripple-carry adder core.
// One job in flight at a time, per-job watchdog, sticky timeout flag, 8-bit completed-job counter.
module rca_job_arbiter #(
  parameter int W   = 3,
  parameter int TMO = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_cin,
  output logic [1:0]     req_ready,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic           ap_start,
  input  logic           ap_ready,
  input  logic           ap_done,
  input  logic           ap_idle,
  output logic [W-1:0]   core_a,
  output logic [W-1:0]   core_b,
  output logic           core_cin,
  input  logic [W-1:0]   core_sum,
  input  logic           core_cout,
  output logic           busy,
  output logic           timeout_err,
  output logic [7:0]     job_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RESPOND} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last;
  logic         r_id;
  logic [7:0]   r_wdog;
  logic         r_err;
  logic [7:0]   r_cnt;
  logic [W-1:0] r_core_a;
  logic [W-1:0] r_core_b;
  logic         r_core_cin;
  logic [W-1:0] r_rsp_sum;
  logic         r_rsp_cout;

  logic w_gnt;
  logic w_accept;
  logic w_capture;
  logic w_tmo_hit;
  logic w_rsp_done;
  logic w_wdog_lim;
  logic w_unused;

  assign w_unused = ap_idle;

  // Tie goes to the requester that was not served last.
  assign w_gnt = (req_valid == 2'b10) ? 1'b1 :
                 (req_valid == 2'b01) ? 1'b0 : ~r_last;

  assign w_wdog_lim = (r_wdog == 8'(TMO - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_tmo_hit  = 1'b0;
    w_rsp_done = 1'b0;
    ap_start   = 1'b0;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!reset) begin
          req_ready[0] = req_valid[0] && !w_gnt;
          req_ready[1] = req_valid[1] &&  w_gnt;
        end
        if (|req_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ap_start = 1'b1;
        // A completing core wins over a watchdog expiring on the same edge.
        if (ap_ready && ap_done) begin
          w_capture = 1'b1;
          w_next    = S_RESPOND;
        end else if (w_wdog_lim) begin
          ap_start  = 1'b0;
          w_tmo_hit = 1'b1;
          w_next    = S_IDLE;
        end else if (ap_ready) begin
          w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (ap_done) begin
          w_capture = 1'b1;
          w_next    = S_RESPOND;
        end else if (w_wdog_lim) begin
          w_tmo_hit = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RESPOND: begin
        rsp_valid[r_id] = 1'b1;
        if (rsp_ready[r_id]) begin
          w_rsp_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_wdog     <= 8'd0;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
      r_core_a   <= '0;
      r_core_b   <= '0;
      r_core_cin <= 1'b0;
      r_rsp_sum  <= '0;
      r_rsp_cout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_a   <= w_gnt ? req_a[2*W-1:W] : req_a[W-1:0];
        r_core_b   <= w_gnt ? req_b[2*W-1:W] : req_b[W-1:0];
        r_core_cin <= req_cin[w_gnt];
        r_id       <= w_gnt;
        r_last     <= w_gnt;
        r_wdog     <= 8'd0;
      end else if (r_state == S_ISSUE || r_state == S_WAIT_DONE) begin
        r_wdog <= r_wdog + 8'd1;
      end
      if (w_capture) begin
        r_rsp_sum  <= core_sum;
        r_rsp_cout <= core_cout;
      end
      if (w_tmo_hit)  r_err <= 1'b1;
      if (w_rsp_done) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign core_a      = r_core_a;
  assign core_b      = r_core_b;
  assign core_cin    = r_core_cin;
  assign rsp_sum     = r_rsp_sum;
  assign rsp_cout    = r_rsp_cout;
  assign timeout_err = r_err;
  assign job_count   = r_cnt;

endmodule

// File: tb/tb_rca_job_arbiter.sv
// Directed bench for rca_job_arbiter with a behavioural ap_ctrl_hs adder core
// whose latency, hang and same-cycle ready/done behaviour are set per test.
module tb_rca_job_arbiter;
  localparam int W = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     req_valid = '0;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [1:0]     req_cin = '0;
  logic [1:0]     req_ready, rsp_valid;
  logic [1:0]     rsp_ready = '0;
  logic [W-1:0]   rsp_sum, core_a, core_b, core_sum;
  logic           rsp_cout, ap_start, ap_ready, ap_done, ap_idle;
  logic           core_cin, core_cout, busy, timeout_err;
  logic [7:0]     job_count;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  logic fast = 1'b0;
  logic hang = 1'b0;

  rca_job_arbiter #(.W(W), .TMO(64)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .core_a(core_a), .core_b(core_b),
    .core_cin(core_cin), .core_sum(core_sum), .core_cout(core_cout), .busy(busy),
    .timeout_err(timeout_err), .job_count(job_count)
  );

  always #5 clock = ~clock;

  // Behavioural core: accepts when idle, raises done lat cycles after the accepting cycle.
  logic c_busy;
  int   c_cnt;
  assign ap_ready = fast ? ap_start : (ap_start && !c_busy);
  assign ap_done  = fast ? ap_start : (c_busy && c_cnt == 0 && !hang);
  assign ap_idle  = !c_busy;
  assign {core_cout, core_sum} = {1'b0, core_a} + {1'b0, core_b} + {3'b000, core_cin};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      c_busy <= 1'b0;
      c_cnt  <= 0;
    end else if (!fast) begin
      if (ap_start && !c_busy) begin
        c_busy <= 1'b1;
        c_cnt  <= lat;
      end else if (ap_done) begin
        c_busy <= 1'b0;
      end else if (c_busy && c_cnt != 0) begin
        c_cnt <= c_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic do_job(input string nm, input logic [1:0] req,
                        input logic [2:0] a0, input logic [2:0] b0, input logic c0,
                        input logic [2:0] a1, input logic [2:0] b1, input logic c1,
                        input int exp_lat, input logic [1:0] exp_rdy,
                        input logic [2:0] exp_sum, input logic exp_cout,
                        input logic [7:0] exp_cnt);
    int cyc;
    req_valid = req;
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_cin = {c1, c0};
    #1;
    chk({nm, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clock); #1;
    req_valid = 2'b00;
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({nm, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_rdy));
    chk({nm, ".rsp_sum"}, 32'(rsp_sum), 32'(exp_sum));
    chk({nm, ".rsp_cout"}, 32'(rsp_cout), 32'(exp_cout));
    rsp_ready = exp_rdy;
    @(posedge clock); #1;
    rsp_ready = 2'b00;
    chk({nm, ".rsp_valid_off"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".idle"}, 32'(busy), 32'd0);
    chk({nm, ".job_count"}, 32'(job_count), 32'(exp_cnt));
    @(negedge clock);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [2:0] a0, b0;
    logic       c0;
    logic [2:0] a1, b1;
    logic       c1;
    int         lat;
    logic       fast;
    logic [1:0] exp_rdy;
    logic [2:0] exp_sum;
    logic       exp_cout;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int seen;
    tbl[0] = '{1'b1, 2'b01, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 0, 1'b0, 2'b01, 3'd0, 1'b1, 8'd1};
    tbl[1] = '{1'b1, 2'b11, 3'd1, 3'd1, 1'b0, 3'd2, 3'd3, 1'b1, 1, 1'b0, 2'b01, 3'd2, 1'b0, 8'd1};
    tbl[2] = '{1'b0, 2'b11, 3'd1, 3'd1, 1'b0, 3'd2, 3'd3, 1'b1, 0, 1'b0, 2'b10, 3'd6, 1'b0, 8'd2};
    tbl[3] = '{1'b0, 2'b11, 3'd4, 3'd4, 1'b1, 3'd2, 3'd3, 1'b1, 0, 1'b1, 2'b01, 3'd1, 1'b1, 8'd3};
    tbl[4] = '{1'b0, 2'b10, 3'd0, 3'd0, 1'b0, 3'd7, 3'd0, 1'b0, 3, 1'b0, 2'b10, 3'd7, 1'b0, 8'd4};
    tbl[5] = '{1'b0, 2'b01, 3'd6, 3'd1, 1'b1, 3'd0, 3'd0, 1'b0, 0, 1'b0, 2'b01, 3'd0, 1'b1, 8'd5};
    tbl[6] = '{1'b0, 2'b10, 3'd0, 3'd0, 1'b0, 3'd5, 3'd5, 1'b1, 2, 1'b0, 2'b10, 3'd3, 1'b1, 8'd6};
    tbl[7] = '{1'b0, 2'b11, 3'd2, 3'd2, 1'b0, 3'd5, 3'd5, 1'b1, 0, 1'b0, 2'b01, 3'd4, 1'b0, 8'd7};

    req_valid = 2'b11;
    @(negedge clock); #1;
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.ap_start", 32'(ap_start), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.job_count", 32'(job_count), 32'd0);
    chk("reset.timeout_err", 32'(timeout_err), 32'd0);
    chk("reset.core", 32'({core_a, core_b, core_cin, rsp_sum, rsp_cout}), 32'd0);
    req_valid = 2'b00;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) pulse_reset();
      lat  = tbl[i].lat;
      fast = tbl[i].fast;
      do_job($sformatf("row%0d", i), tbl[i].req, tbl[i].a0, tbl[i].b0, tbl[i].c0,
             tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].fast ? 1 : 2 + tbl[i].lat,
             tbl[i].exp_rdy, tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].exp_cnt);
    end
    fast = 1'b0;
    lat  = 0;

    // A request withdrawn between edges is never accepted.
    @(posedge clock); #1;
    req_valid = 2'b01;
    #1;
    chk("glitch.req_ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    @(posedge clock); #1;
    chk("glitch.busy", 32'(busy), 32'd0);
    @(negedge clock);

    // Watchdog: core never finishes.
    hang = 1'b1;
    req_valid = 2'b01;
    req_a = {3'd0, 3'd1};
    req_b = {3'd0, 3'd1};
    req_cin = 2'b00;
    @(posedge clock); #1;
    req_valid = 2'b00;
    seen = 0;
    for (int k = 0; k < 63; k++) begin
      @(posedge clock); #1;
      if (rsp_valid != 2'b00) seen++;
    end
    chk("tmo.err_before", 32'(timeout_err), 32'd0);
    chk("tmo.busy_before", 32'(busy), 32'd1);
    @(posedge clock); #1;
    chk("tmo.err", 32'(timeout_err), 32'd1);
    chk("tmo.idle", 32'(busy), 32'd0);
    chk("tmo.ap_start", 32'(ap_start), 32'd0);
    chk("tmo.no_rsp", 32'(seen), 32'd0);
    chk("tmo.job_count", 32'(job_count), 32'd7);
    hang = 1'b0;
    repeat (2) @(negedge clock);
    do_job("after_tmo", 2'b01, 3'd1, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0, 2, 2'b01, 3'd3, 1'b0, 8'd8);
    chk("tmo.sticky", 32'(timeout_err), 32'd1);

    // Response held off for 10 cycles with a competing request and a stray rsp_ready.
    req_valid = 2'b10;
    req_a = {3'd6, 3'd0};
    req_b = {3'd3, 3'd0};
    req_cin = 2'b00;
    @(posedge clock); #1;
    req_valid = 2'b00;
    seen = 0;
    while (rsp_valid == 2'b00 && seen < 100) begin
      @(posedge clock); #1;
      seen++;
    end
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (rsp_valid != 2'b10 || rsp_sum != 3'd1 || rsp_cout != 1'b1 ||
          req_ready != 2'b00 || core_a != 3'd6 || core_b != 3'd3 || !busy) seen++;
    end
    chk("stall.hold", 32'(seen), 32'd0);
    rsp_ready = 2'b10;
    @(posedge clock); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    chk("stall.job_count", 32'(job_count), 32'd9);
    chk("stall.rsp_off", 32'(rsp_valid), 32'd0);
    @(negedge clock);

    // Reset while waiting on the core.
    lat = 20;
    req_valid = 2'b01;
    req_a = {3'd0, 3'd5};
    req_b = {3'd0, 3'd2};
    req_cin = 2'b01;
    @(posedge clock); #1;
    repeat (3) @(posedge clock);
    #1;
    chk("midrst.busy_before", 32'(busy), 32'd1);
    req_valid = 2'b11;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.req_ready", 32'(req_ready), 32'd0);
    chk("midrst.ap_start", 32'(ap_start), 32'd0);
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst.err", 32'(timeout_err), 32'd0);
    chk("midrst.job_count", 32'(job_count), 32'd0);
    chk("midrst.core", 32'({core_a, core_b, core_cin, rsp_sum, rsp_cout}), 32'd0);
    req_valid = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    lat = 0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (rsp_valid != 2'b00 || busy) seen++;
    end
    chk("midrst.silent", 32'(seen), 32'd0);
    @(negedge clock);

    // 256 jobs wrap the counter.
    lat = 1;
    for (int i = 0; i < 256; i++) begin
      do_job($sformatf("wrap%0d", i), (i % 2 == 1) ? 2'b10 : 2'b01,
             3'd7, 3'd7, 1'b1, 3'd7, 3'd7, 1'b1, 3,
             (i % 2 == 1) ? 2'b10 : 2'b01, 3'd7, 1'b1, 8'((i + 1) % 256));
    end
    chk("wrap.final", 32'(job_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/rca_job_arbiter.md
RCA_JOB_ARBITER -- requirements
Module: rca_job_arbiter

Interface
REQ-001 Parameter: W, default 3, operand/sum width of the shared ripple-carry adder core.
REQ-002 Parameter: TMO, default 64, watchdog limit in cycles per job (range 2..255).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester job request; bit i belongs to requester i.
REQ-006 req_a, req_b  in  2*W each  operands; slice [i*W +: W] belongs to requester i.
REQ-007 req_cin  in  2  carry-in per requester.
REQ-008 req_ready  out  2  job-accept strobe per requester.
REQ-009 rsp_valid  out  2  result-valid per requester.
REQ-010 rsp_ready  in  2  result-accept per requester.
REQ-011 rsp_sum  out  W  shared result bus; rsp_cout  out  1  shared carry-out.
REQ-012 ap_start  out  1; ap_ready, ap_done, ap_idle  in  1 each  ap_ctrl_hs handshake to the adder core.
REQ-013 core_a, core_b  out  W; core_cin  out  1; core_sum  in  W; core_cout  in  1  core datapath.
REQ-014 busy  out  1; timeout_err  out  1 (sticky); job_count  out  8.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, RESPOND; encoding is free.
REQ-016 In IDLE, req_ready[i] SHALL be high combinationally iff req_valid[i] and requester i holds the grant; a job is accepted on a clock edge where req_valid[i] and req_ready[i] are both high.
REQ-017 Grant: only one requester valid -> that requester; both valid -> the requester not granted last (round-robin); last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-018 On acceptance, operands and cin SHALL be latched into core_a/core_b/core_cin, the grant ID SHALL be latched, and FSM -> ISSUE.
REQ-019 ap_start SHALL be high in ISSUE only; ISSUE -> WAIT_DONE on the edge where ap_ready=1.
REQ-020 ap_ready and ap_done high in the same cycle in ISSUE -> go directly to RESPOND, capturing the result.
REQ-021 WAIT_DONE -> RESPOND on ap_done=1; core_sum and core_cout SHALL be registered into rsp_sum/rsp_cout on that edge.
REQ-022 In RESPOND, rsp_valid[id]=1 and the other bit =0; hold the result stable until rsp_ready[id]=1, then -> IDLE and increment job_count (mod 256, 255 wraps to 0).
REQ-023 Minimum accept-to-rsp_valid latency: 2 cycles plus core latency; back-to-back jobs SHALL have at least one IDLE cycle between them.
REQ-024 core_a/core_b/core_cin SHALL remain stable from ISSUE entry until RESPOND exit.
REQ-025 Watchdog: a counter cleared on acceptance and incremented each cycle in ISSUE/WAIT_DONE; on reaching TMO: set timeout_err, drop ap_start, go IDLE, no rsp_valid, no job_count increment.
REQ-026 timeout_err SHALL clear only on reset.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 req_valid deasserted in IDLE before acceptance SHALL have no effect; rsp_ready on a non-granted bit SHALL be ignored.
REQ-029 ap_idle is informational only and SHALL NOT gate transitions.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, ap_start=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, core_a=core_b=0, core_cin=0, busy=0, timeout_err=0, job_count=0, watchdog=0, last-grant=1.
REQ-031 Reset asserted mid-job SHALL abandon the job without a response; the core shares the same reset.

Verification
REQ-032 Single job req0: a=3,b=5,cin=0 -> rsp_valid=2'b01, rsp_sum=0, rsp_cout=1, job_count=1.
REQ-033 Both valid in the same cycle after reset -> requester 0 served first, then requester 1; next tie -> requester 0.
REQ-034 Core ap_done held low forever, TMO=64 -> timeout_err=1 after 64 cycles, FSM returns to IDLE, next job completes normally.
REQ-035 rsp_ready held low 10 cycles in RESPOND -> rsp_sum/rsp_cout/rsp_valid held stable; no new req_ready during that time.
REQ-036 Reset asserted while in WAIT_DONE -> all outputs at reset values in the same cycle; no response is emitted afterwards.
REQ-037 256 jobs with a=7,b=7,cin=1 -> every rsp_sum=7, rsp_cout=1; job_count wraps to 0.
